// File: rtl/mc_mem_if.sv
// mc_mem_if: IR/MDR memory port of the multi-cycle MIPS core, one req/ack bus transaction per request.
// Optional MEM_ALIGN_CHK_EN: misaligned data accesses are rejected with err instead of being masked.
module mc_mem_if #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          IorD,
    input  logic          IRWrite,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] aluout,
    input  logic [DW-1:0] wdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [DW-1:0] instr,
    output logic [5:0]    Op,
    output logic [5:0]    Funct,
    output logic [DW-1:0] mdr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;
    typedef enum logic [1:0] {DstNone, DstIr, DstMdr} dest_e;

    localparam logic [7:0]    TimeoutLast = 8'(TIMEOUT_CYC - 1);
    localparam logic [AW-1:0] WordMask    = ~AW'(3);

    state_e        state_q, state_d;
    dest_e         dest_q, dest_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [DW-1:0] mdr_q, mdr_d;
    logic [7:0]    wait_q, wait_d;
    logic          err_q, err_d;
    logic          start;
    logic          misaligned;
    logic [AW-1:0] sel_addr;

    assign start    = (state_q == StIdle) & (IRWrite | MemRead | MemWrite);
    assign sel_addr = IorD ? aluout : pc;

`ifdef MEM_ALIGN_CHK_EN
    assign misaligned = IorD & (aluout[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        instr_d = instr_q;
        mdr_d   = mdr_q;
        wait_d  = wait_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (misaligned) begin
                        // Rejected before reaching the bus; still reports completion.
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StReq;
                        addr_d  = sel_addr & WordMask;
                        we_d    = MemWrite;
                        wdata_d = wdata;
                        wait_d  = '0;
                        if (MemWrite) begin
                            dest_d = DstNone;
                        end else if (IRWrite) begin
                            dest_d = DstIr;
                        end else begin
                            dest_d = DstMdr;
                        end
                    end
                end
            end
            StReq: begin
                if (mem_ack) begin
                    state_d = StDone;
                    if (dest_q == DstIr) begin
                        instr_d = mem_rdata;
                    end else if (dest_q == DstMdr) begin
                        mdr_d = mem_rdata;
                    end
                end else if (wait_q == TimeoutLast) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            dest_q  <= DstNone;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            instr_q <= '0;
            mdr_q   <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            instr_q <= instr_d;
            mdr_q   <= mdr_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Bus strobes decode straight from the state register so reset drops them immediately.
    assign mem_req   = (state_q == StReq);
    assign mem_we    = we_q & mem_req;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = mem_req | start;
    assign done      = (state_q == StDone);
    assign err       = err_q;
    assign instr     = instr_q;
    assign Op        = instr_q[31:26];
    assign Funct     = instr_q[5:0];
    assign mdr       = mdr_q;

endmodule

// File: tb/tb_mc_mem_if.sv
// Scoreboard bench for mc_mem_if: a transaction-level model predicts IR/MDR/err/latency per request,
// a bus responder plays the external memory, and a done monitor checks completions.
module tb_mc_mem_if;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        IorD, IRWrite, MemRead, MemWrite;
    logic [31:0] pc, aluout, wdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] instr, mdr;
    logic [5:0]  Op, Funct;
    logic        busy, done, err;

    always #5 clk = ~clk;

    mc_mem_if #(.AW(32), .DW(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .pc(pc), .aluout(aluout), .wdata(wdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .instr(instr), .Op(Op), .Funct(Funct), .mdr(mdr), .busy(busy),
        .done(done), .err(err)
    );

    typedef struct {
        int          issue;
        int          lat;
        logic [31:0] instr;
        logic [31:0] mdr;
        logic        err;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          delay;   // REQ cycles before ack; negative = never ack
    } bus_t;

    done_t       dq[$];
    bus_t        bq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] ref_mem[int];
    logic [31:0] bus_mem[int];
    logic [31:0] ir_m = '0;
    logic [31:0] mdr_m = '0;
    logic        err_m = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dflt(input int w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
    endfunction

    function automatic logic [31:0] bus_rd(input int w);
        return bus_mem.exists(w) ? bus_mem[w] : dflt(w);
    endfunction

    // External memory: acks after the delay the scoreboard entry asks for.
    bus_t cur;
    logic in_req = 1'b0;
    int   n_req = 0;
    always @(negedge clk) begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (rst) begin
            in_req = 1'b0;
        end else if (mem_req) begin
            if (!in_req) begin
                in_req = 1'b1;
                n_req  = 0;
                if (bq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL bus_unexpected: mem_req with no request pending (cycle %0d)", cyc);
                    cur = '{addr: 32'h0, we: 1'b0, wdata: 32'h0, delay: -1};
                end else begin
                    cur = bq.pop_front();
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("mem_we", 32'(mem_we), 32'(cur.we));
                    if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                end
            end else begin
                n_req++;
            end
            chk("busy_in_req", 32'(busy), 32'd1);
            if (n_req == cur.delay) begin
                mem_ack = 1'b1;
                if (mem_we) bus_mem[int'(mem_addr >> 2)] = mem_wdata;
                else mem_rdata = bus_rd(int'(mem_addr >> 2));
            end
        end else begin
            // A stray ack right after an abandoned request must be ignored.
            if (in_req && cur.delay < 0) mem_ack = 1'b1;
            in_req = 1'b0;
        end
    end

    // Completion monitor.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (dq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_unexpected: done with nothing outstanding (cycle %0d)", cyc);
            end else begin
                done_t e;
                e = dq.pop_front();
                chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                chk("instr", instr, e.instr);
                chk("Op", 32'(Op), 32'(e.instr[31:26]));
                chk("Funct", 32'(Funct), 32'(e.instr[5:0]));
                chk("mdr", mdr, e.mdr);
                chk("err", 32'(err), 32'(e.err));
                chk("busy_in_done", 32'(busy), 32'd0);
                chk("req_in_done", 32'(mem_req), 32'd0);
            end
        end
    end

    task automatic issue(input logic iord, input logic irw, input logic mrd, input logic mwr,
                         input logic [31:0] pcv, input logic [31:0] alu, input logic [31:0] wd,
                         input int delay);
        logic [31:0] a;
        logic        mis;
        logic        ok;
        done_t       e;
        int          w;
        a   = iord ? alu : pcv;
        w   = int'(a >> 2);
        mis = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
        mis = iord && (alu[1:0] != 2'b00);
`endif
        e.issue = cyc;
        if (mis) begin
            e.lat = 1;
            err_m = 1'b1;
        end else begin
            bq.push_back('{addr: a & ~32'h3, we: mwr, wdata: wd, delay: delay});
            if (delay < 0) begin
                e.lat = 1 + int'(TO);
                err_m = 1'b1;
            end else begin
                e.lat = 2 + delay;
                if (mwr) ref_mem[w] = wd;
                else if (irw) ir_m = ref_rd(w);
                else mdr_m = ref_rd(w);
            end
        end
        e.instr = ir_m;
        e.mdr   = mdr_m;
        e.err   = err_m;
        dq.push_back(e);
        IorD = iord; IRWrite = irw; MemRead = mrd; MemWrite = mwr;
        pc = pcv; aluout = alu; wdata = wd;
        #1 chk("busy_on_start", 32'(busy), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = done;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_wait: no done within 40 cycles (cycle %0d)", cyc);
        end
        IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_issue(input bit allow_timeout);
        logic [2:0] r;
        int         d;
        r = 3'($urandom_range(1, 7));
        d = (allow_timeout && $urandom_range(0, 6) == 0) ? -1 : $urandom_range(0, TO - 1);
        issue(1'($urandom_range(0, 1)), r[0], r[1], r[2], 32'($urandom_range(0, 'h3FF)),
              32'($urandom_range(0, 'h3FF)), $urandom, d);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        IorD = 1'b0; IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        pc = '0; aluout = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_mdr", mdr, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Zero-wait fetch.
        ref_mem[4] = 32'h2008_0005;
        bus_mem[4] = 32'h2008_0005;
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 0);

        // Reset in the middle of a request.
        bq.push_back('{addr: 32'h20, we: 1'b0, wdata: 32'h0, delay: -1});
        IorD = 1'b0; IRWrite = 1'b1; pc = 32'h20;
        @(posedge clk);
        #1 chk("req_held", 32'(mem_req), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_req", 32'(mem_req), 32'd0);
        IRWrite = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst2_instr", instr, 32'h0);
        chk("rst2_err", 32'(err), 32'd0);
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_done", 32'(done), 32'd0);
        ir_m = '0; mdr_m = '0; err_m = 1'b0;
        @(posedge clk);
        #1;

        // Load with three wait states, then a store.
        ref_mem[32'h40] = 32'hDEAD_BEEF;
        bus_mem[32'h40] = 32'hDEAD_BEEF;
        issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0, 3);
        issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h104, 32'h1234_5678, 1);

        for (int i = 0; i < 40; i++) rand_issue(1'b0);

        // Timeout, then a misaligned data load.
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 32'h0, -1);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h102, 32'h0, 1);

        for (int i = 0; i < 20; i++) rand_issue(1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(dq.size()), 32'd0);
        chk("bus_drained", 32'(bq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
